reduce_adder_sched: RTL

- Time-shares the single pipelined FP adder (fixed latency AdderLatency) among the ReductionTableSize reduction-table slots.
- Each slot raises a request carrying its two operands; the block grants one slot per cycle, round-robin, and drives the adder inputs.
- It tracks in-flight slot indices through a latency-matched shift pipe and returns each sum tagged with its slot index.
- Sits between the reduction table and the adder IP, replacing per-slot wait counters.

---
 rtl/reduce_adder_sched_pkg.sv | 12 +
 rtl/reduce_adder_sched_rr_arbiter.sv | 28 ++
 rtl/reduce_adder_sched.sv | 85 ++++++++
 3 files changed

// File: rtl/reduce_adder_sched_pkg.sv
// Shared constants and pipe entry type for the reduction-table adder scheduler.
package reduce_adder_sched_pkg;
   localparam int ReductionTableSize = 8;
   localparam int IndexWidth         = 3;
   localparam int PayloadWidth       = 32;
   localparam int AdderLatency       = 14;

   typedef struct packed {
      logic                  valid;
      logic [IndexWidth-1:0] index;
   } pipe_entry_t;
endpackage

// File: rtl/reduce_adder_sched_rr_arbiter.sv
// N-wide round-robin arbiter: first requester at or above ptr, wrapping to 0.
module rr_arbiter #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index,
   output logic          found
);
   logic [IW-1:0] idx;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            index      = idx;
            grant[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/reduce_adder_sched.sv
// Time-shares one pipelined FP adder among the reduction-table slots and
// returns each sum tagged with the slot that issued it.
module reduce_adder_sched
   import reduce_adder_sched_pkg::*;
(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [ReductionTableSize-1:0]          req,
   input  logic [ReductionTableSize*PayloadWidth-1:0] req_a,
   input  logic [ReductionTableSize*PayloadWidth-1:0] req_b,
   output logic [ReductionTableSize-1:0]          gnt,
   output logic [PayloadWidth-1:0]                add_a,
   output logic [PayloadWidth-1:0]                add_b,
   output logic                                   add_valid,
   input  logic [PayloadWidth-1:0]                add_sum,
   output logic                                   res_valid,
   output logic [IndexWidth-1:0]                  res_index,
   output logic [PayloadWidth-1:0]                res_data,
   output logic [ReductionTableSize-1:0]          busy,
   output logic [IndexWidth:0]                    inflight
);
   logic [ReductionTableSize-1:0] eligible;
   logic [ReductionTableSize-1:0] grant_next;
   logic [IndexWidth-1:0]         idx_next;
   logic                          found;
   logic [IndexWidth-1:0]         rr_ptr;
   logic [IndexWidth-1:0]         issue_idx;
   logic [ReductionTableSize-1:0] ret_mask;
   pipe_entry_t                   pipe [AdderLatency];
   pipe_entry_t                   tail;

   // busy still holds for a slot returning this edge, which gives the
   // one-cycle same-slot turnaround gap for free
   assign eligible = req & ~busy;
   assign tail     = pipe[AdderLatency-1];
   assign ret_mask = tail.valid ? (ReductionTableSize'(1) << tail.index) : '0;

   rr_arbiter #(
      .N  (ReductionTableSize),
      .IW (IndexWidth)
   ) u_arb (
      .req   (eligible),
      .ptr   (rr_ptr),
      .grant (grant_next),
      .index (idx_next),
      .found (found)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt       <= '0;
         add_a     <= '0;
         add_b     <= '0;
         add_valid <= 1'b0;
         res_valid <= 1'b0;
         res_index <= '0;
         res_data  <= '0;
         busy      <= '0;
         inflight  <= '0;
         rr_ptr    <= '0;
         issue_idx <= '0;
         for (int i = 0; i < AdderLatency; i++) pipe[i] <= '0;
      end else begin
         gnt       <= grant_next;
         add_valid <= found;
         if (found) begin
            add_a     <= req_a[int'(idx_next)*PayloadWidth +: PayloadWidth];
            add_b     <= req_b[int'(idx_next)*PayloadWidth +: PayloadWidth];
            issue_idx <= idx_next;
            rr_ptr    <= IndexWidth'((int'(idx_next) + 1) % ReductionTableSize);
         end
         // pipe is fed from the adder input register so its tail lines up with add_sum
         pipe[0] <= '{valid: add_valid, index: issue_idx};
         for (int i = 1; i < AdderLatency; i++) pipe[i] <= pipe[i-1];
         res_valid <= tail.valid;
         if (tail.valid) begin
            res_index <= tail.index;
            res_data  <= add_sum;
         end
         busy     <= (busy | grant_next) & ~ret_mask;
         inflight <= inflight + {{IndexWidth{1'b0}}, found}
                              - {{IndexWidth{1'b0}}, tail.valid};
      end
   end
endmodule
